// File: rtl/fifo_port_sched.sv
// Write-side round-robin burst arbiter and read-side sequencer for an 8-bit, 32-deep FIFO.
// Guards the FIFO against writes when full and reads when empty, and keeps sticky error flags.
module fifo_port_sched #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_gnt,
    input  logic              b_req,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_gnt,
    output logic              fifo_wrt_sig,
    output logic [DATA_W-1:0] fifo_din,
    output logic              fifo_rd_sig,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_full_sig,
    input  logic              fifo_empty_sig,
    input  logic              fifo_over_flow,
    input  logic              fifo_under_flow,
    input  logic              rd_req,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              err_ovf,
    output logic              err_udf,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  a_cnt,
    output logic [CNT_W-1:0]  b_cnt
);

    typedef enum logic [1:0] {StIdle, StOwnA, StOwnB} state_e;

    localparam logic [3:0] BeatLast = 4'(BURST_LEN - 1);

    state_e             state_q, state_d;
    logic               last_q, last_d;  // 1: B was the last owner
    logic [3:0]         beat_q, beat_d;
    logic               rd_valid_q;
    logic               err_ovf_q, err_ovf_d;
    logic               err_udf_q, err_udf_d;
    logic [CNT_W-1:0]   a_cnt_q, b_cnt_q;
    logic               acc_a, acc_b;

    assign acc_a = (state_q == StOwnA) && a_req && !fifo_full_sig;
    assign acc_b = (state_q == StOwnB) && b_req && !fifo_full_sig;

    assign a_gnt        = (state_q == StOwnA);
    assign b_gnt        = (state_q == StOwnB);
    assign fifo_wrt_sig = acc_a || acc_b;
    assign fifo_din     = acc_a ? a_data : (acc_b ? b_data : '0);

    assign fifo_rd_sig = rd_req && !fifo_empty_sig;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_valid_q ? fifo_dout : '0;

    assign err_ovf = err_ovf_q;
    assign err_udf = err_udf_q;
    assign a_cnt   = a_cnt_q;
    assign b_cnt   = b_cnt_q;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        beat_d  = beat_q;
        unique case (state_q)
            StIdle: begin
                if (a_req && (!b_req || last_q)) begin
                    state_d = StOwnA;
                end else if (b_req) begin
                    state_d = StOwnB;
                end
            end
            StOwnA: begin
                if (!a_req) begin
                    state_d = b_req ? StOwnB : StIdle;
                    last_d  = 1'b0;
                    beat_d  = '0;
                end else if (acc_a) begin
                    if (beat_q == BeatLast) begin
                        beat_d = '0;
                        if (b_req) begin
                            state_d = StOwnB;
                            last_d  = 1'b0;
                        end
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            StOwnB: begin
                if (!b_req) begin
                    state_d = a_req ? StOwnA : StIdle;
                    last_d  = 1'b1;
                    beat_d  = '0;
                end else if (acc_b) begin
                    if (beat_q == BeatLast) begin
                        beat_d = '0;
                        if (a_req) begin
                            state_d = StOwnA;
                            last_d  = 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                beat_d  = '0;
            end
        endcase
    end

    // A fresh error indication takes priority over a simultaneous clear.
    always_comb begin
        err_ovf_d = err_ovf_q;
        err_udf_d = err_udf_q;
        if (err_clr) begin
            err_ovf_d = 1'b0;
            err_udf_d = 1'b0;
        end
        if (fifo_over_flow) err_ovf_d = 1'b1;
        if (fifo_under_flow) err_udf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            last_q     <= 1'b1;
            beat_q     <= '0;
            rd_valid_q <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_udf_q  <= 1'b0;
            a_cnt_q    <= '0;
            b_cnt_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            beat_q     <= beat_d;
            rd_valid_q <= fifo_rd_sig;
            err_ovf_q  <= err_ovf_d;
            err_udf_q  <= err_udf_d;
            if (acc_a && (a_cnt_q != '1)) a_cnt_q <= a_cnt_q + 1'b1;
            if (acc_b && (b_cnt_q != '1)) b_cnt_q <= b_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_port_sched.sv
// Directed bench for fifo_port_sched with a behavioural 32-deep FIFO model.
module tb_fifo_port_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, b_req, rd_req, err_clr;
    logic [7:0]  a_data, b_data;
    logic        a_gnt, b_gnt, fifo_wrt_sig, fifo_rd_sig, rd_valid, err_ovf, err_udf;
    logic [7:0]  fifo_din, fifo_dout, rd_data;
    logic        fifo_full_sig, fifo_empty_sig, fifo_over_flow, fifo_under_flow;
    logic [15:0] a_cnt, b_cnt;
    logic        force_ovf, force_udf;

    // Saturation instance outputs
    logic        s_a_gnt, s_b_gnt, s_wrt, s_rd, s_rd_valid, s_ovf, s_udf;
    logic [7:0]  s_din, s_rd_data;
    logic [3:0]  s_a_cnt, s_b_cnt;

    int total = 0;
    int bad   = 0;
    int a_idx, b_idx, a_base, a_step, b_base;

    logic [7:0] mem [32];
    int         wp, rp, cnt;
    logic [7:0] dout_q;

    always #5 clk = ~clk;

    assign fifo_full_sig   = (cnt == 32);
    assign fifo_empty_sig  = (cnt == 0);
    assign fifo_dout       = dout_q;
    assign fifo_over_flow  = force_ovf || (fifo_wrt_sig && cnt == 32);
    assign fifo_under_flow = force_udf || (fifo_rd_sig && cnt == 0);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= 0; rp <= 0; cnt <= 0; dout_q <= 8'h00;
        end else begin
            if (fifo_wrt_sig && cnt < 32) begin
                mem[wp % 32] <= fifo_din;
                wp <= wp + 1;
            end
            if (fifo_rd_sig && cnt > 0) begin
                dout_q <= mem[rp % 32];
                rp <= rp + 1;
            end
            cnt <= cnt + ((fifo_wrt_sig && cnt < 32) ? 1 : 0) - ((fifo_rd_sig && cnt > 0) ? 1 : 0);
        end
    end

    fifo_port_sched u_dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_data(a_data), .a_gnt(a_gnt),
        .b_req(b_req), .b_data(b_data), .b_gnt(b_gnt),
        .fifo_wrt_sig(fifo_wrt_sig), .fifo_din(fifo_din),
        .fifo_rd_sig(fifo_rd_sig), .fifo_dout(fifo_dout),
        .fifo_full_sig(fifo_full_sig), .fifo_empty_sig(fifo_empty_sig),
        .fifo_over_flow(fifo_over_flow), .fifo_under_flow(fifo_under_flow),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
        .err_ovf(err_ovf), .err_udf(err_udf), .err_clr(err_clr),
        .a_cnt(a_cnt), .b_cnt(b_cnt)
    );

    fifo_port_sched #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_data(a_data), .a_gnt(s_a_gnt),
        .b_req(b_req), .b_data(b_data), .b_gnt(s_b_gnt),
        .fifo_wrt_sig(s_wrt), .fifo_din(s_din),
        .fifo_rd_sig(s_rd), .fifo_dout(fifo_dout),
        .fifo_full_sig(fifo_full_sig), .fifo_empty_sig(fifo_empty_sig),
        .fifo_over_flow(fifo_over_flow), .fifo_under_flow(fifo_under_flow),
        .rd_req(rd_req), .rd_valid(s_rd_valid), .rd_data(s_rd_data),
        .err_ovf(s_ovf), .err_udf(s_udf), .err_clr(err_clr),
        .a_cnt(s_a_cnt), .b_cnt(s_b_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_data();
        a_data = 8'(a_base + a_idx * a_step);
        b_data = 8'(b_base + b_idx);
    endtask

    // Advance one clock; the producers move to their next word after an accepted beat.
    task automatic cycle();
        logic acc_a, acc_b;
        #3;
        acc_a = fifo_wrt_sig && a_gnt;
        acc_b = fifo_wrt_sig && b_gnt;
        @(posedge clk);
        #1;
        if (acc_a) a_idx++;
        if (acc_b) b_idx++;
        drive_data();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        a_idx = 0;
        b_idx = 0;
        drive_data();
    endtask

    logic [7:0] rr_exp [16] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h80, 8'h81, 8'h82, 8'h83,
                                8'h14, 8'h15, 8'h16, 8'h17, 8'h84, 8'h85, 8'h86, 8'h87};
    logic [7:0] rd_exp [5]  = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00};

    initial begin
        rst = 1'b1; a_req = 0; b_req = 0; rd_req = 0; err_clr = 0;
        force_ovf = 0; force_udf = 0;
        a_idx = 0; b_idx = 0; a_base = 8'h10; a_step = 1; b_base = 8'h80;
        drive_data();
        #2;
        check("rst_a_gnt", 32'(a_gnt), 32'd0);
        check("rst_b_gnt", 32'(b_gnt), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_err", 32'({err_ovf, err_udf}), 32'd0);
        check("rst_cnts", 32'({a_cnt, b_cnt}), 32'd0);

        // Reset in the middle of an A burst
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_req = 1'b1;
        cycle();
        check("gnt_after_req", 32'(a_gnt), 32'd1);
        cycle();
        cycle();
        check("mid_burst_a_cnt", 32'(a_cnt), 32'd2);
        check("mid_burst_wrt", 32'(fifo_wrt_sig), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_gnt", 32'({a_gnt, b_gnt}), 32'd0);
        check("async_rst_wrt", 32'(fifo_wrt_sig), 32'd0);
        check("async_rst_din", 32'(fifo_din), 32'd0);
        check("async_rst_a_cnt", 32'(a_cnt), 32'd0);
        a_idx = 0; b_idx = 0;
        drive_data();
        b_req = 1'b1;
        rst = 1'b0;
        cycle();
        check("tie_a_first", 32'({a_gnt, b_gnt}), 32'b10);

        // Round robin with both producers requesting
        for (int k = 0; k < 40 && (a_cnt + b_cnt) < 16; k++) cycle();
        a_req = 0; b_req = 0;
        check("rr_a_cnt", 32'(a_cnt), 32'd8);
        check("rr_b_cnt", 32'(b_cnt), 32'd8);
        check("rr_fifo_cnt", 32'(cnt), 32'd16);
        for (int i = 0; i < 16; i++) check($sformatf("rr_word%0d", i), 32'(mem[i]), 32'(rr_exp[i]));
        cycle();
        check("rr_idle", 32'({a_gnt, b_gnt}), 32'd0);

        // Full stall
        do_reset();
        a_req = 1'b1;
        for (int k = 0; k < 60 && !fifo_full_sig; k++) cycle();
        check("full_a_cnt", 32'(a_cnt), 32'd32);
        check("full_wrt", 32'(fifo_wrt_sig), 32'd0);
        cycle(); cycle(); cycle();
        check("stall_a_cnt", 32'(a_cnt), 32'd32);
        check("stall_gnt", 32'(a_gnt), 32'd1);
        check("stall_wrt", 32'(fifo_wrt_sig), 32'd0);
        rd_req = 1'b1;
        #1;
        check("full_rd_sig", 32'(fifo_rd_sig), 32'd1);
        cycle();
        rd_req = 1'b0;
        #1;
        check("resume_wrt", 32'(fifo_wrt_sig), 32'd1);
        check("resume_rd_valid", 32'(rd_valid), 32'd1);
        check("resume_rd_data", 32'(rd_data), 32'h10);
        cycle();
        check("resume_a_cnt", 32'(a_cnt), 32'd33);
        check("refull", 32'(fifo_full_sig), 32'd1);
        check("no_ovf", 32'(err_ovf), 32'd0);
        a_req = 1'b0;
        cycle();

        // Read handshake
        do_reset();
        a_base = 8'h11; a_step = 8'h11;
        drive_data();
        a_req = 1'b1;
        for (int k = 0; k < 10 && a_cnt < 3; k++) cycle();
        a_req = 1'b0;
        cycle();
        rd_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("rd_sig%0d", k), 32'(fifo_rd_sig), (k < 3) ? 32'd1 : 32'd0);
            cycle();
            check($sformatf("rd_valid%0d", k), 32'(rd_valid), (k < 3) ? 32'd1 : 32'd0);
            check($sformatf("rd_data%0d", k), 32'(rd_data), 32'(rd_exp[k]));
        end
        rd_req = 1'b0;
        check("no_udf", 32'(err_udf), 32'd0);

        // Sticky errors
        force_ovf = 1'b1;
        cycle();
        force_ovf = 1'b0;
        check("ovf_set", 32'(err_ovf), 32'd1);
        cycle();
        check("ovf_sticky", 32'(err_ovf), 32'd1);
        err_clr = 1'b1;
        force_udf = 1'b1;
        cycle();
        err_clr = 1'b0;
        force_udf = 1'b0;
        check("clr_ovf", 32'(err_ovf), 32'd0);
        check("udf_beats_clr", 32'(err_udf), 32'd1);
        cycle();
        check("udf_sticky", 32'(err_udf), 32'd1);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        check("clr_udf", 32'(err_udf), 32'd0);

        // Counter saturation on the narrow-counter instance
        do_reset();
        b_req = 1'b1;
        for (int k = 0; k < 40 && b_cnt < 20; k++) cycle();
        b_req = 1'b0;
        check("sat_wide_b_cnt", 32'(b_cnt), 32'd20);
        check("sat_b_cnt", 32'(s_b_cnt), 32'd15);
        check("sat_a_cnt", 32'(s_a_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
